// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port 256x8 ram.
// Each granted command occupies exactly one ram access cycle followed by a one-cycle ack.
module ram_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state, state_nxt;
    logic              last_grant, last_grant_nxt;  // 1 = B was granted last
    logic              gnt_b, gnt_b_nxt;
    logic              pick_b;
    logic              ram_en_nxt, ram_rw_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_data_nxt;
    logic              a_ack_nxt, b_ack_nxt;
    logic [DATA_W-1:0] a_rdata_nxt, b_rdata_nxt;
    logic              busy_nxt;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        gnt_b_nxt      = gnt_b;
        ram_en_nxt     = ram_en;
        ram_rw_nxt     = ram_rw;
        ram_addr_nxt   = ram_addr;
        ram_data_nxt   = ram_data;
        a_ack_nxt      = 1'b0;
        b_ack_nxt      = 1'b0;
        a_rdata_nxt    = a_rdata;
        b_rdata_nxt    = b_rdata;
        pick_b         = b_req && (!a_req || !last_grant);

        case (state)
            S_IDLE: begin
                if (a_req || b_req) begin
                    gnt_b_nxt      = pick_b;
                    last_grant_nxt = pick_b;
                    ram_rw_nxt     = pick_b ? ~b_we : ~a_we;
                    ram_addr_nxt   = pick_b ? b_addr : a_addr;
                    ram_data_nxt   = pick_b ? b_wdata : a_wdata;
                    ram_en_nxt     = 1'b1;
                    state_nxt      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (ram_rw) begin
                    if (gnt_b) b_rdata_nxt = ram_out;
                    else       a_rdata_nxt = ram_out;
                end
                ram_en_nxt = 1'b0;
                ram_rw_nxt = 1'b1;
                a_ack_nxt  = ~gnt_b;
                b_ack_nxt  = gnt_b;
                state_nxt  = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                ram_en_nxt = 1'b0;
                ram_rw_nxt = 1'b1;
                state_nxt  = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            gnt_b      <= 1'b0;
            ram_en     <= 1'b0;
            ram_rw     <= 1'b1;
            ram_addr   <= '0;
            ram_data   <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            gnt_b      <= gnt_b_nxt;
            ram_en     <= ram_en_nxt;
            ram_rw     <= ram_rw_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_data   <= ram_data_nxt;
            a_ack      <= a_ack_nxt;
            b_ack      <= b_ack_nxt;
            a_rdata    <= a_rdata_nxt;
            b_rdata    <= b_rdata_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule
